// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit register among N requesters; the owner loads it every cycle.
// Latency: grant one edge after req is seen in IDLE, first load one edge later, q_valid the cycle after each load.
// Backpressure: non-owners wait with req high; release on req drop or after MAX_HOLD loads, then one IDLE turnaround.
module rr_reg_arbiter #(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   wdata,
  output logic [N-1:0]          grant,
  output logic [$clog2(N)-1:0]  owner,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid
);

  localparam int OW = $clog2(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] LAST_LOAD = HW'(MAX_HOLD - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state, state_n;
  logic [N-1:0]        grant_n;
  logic [OW-1:0]       owner_n;
  logic [DATA_W-1:0]   q_n;
  logic                q_valid_n;
  logic [OW-1:0]       ptr, ptr_n;
  logic [HW-1:0]       hold_cnt, hold_cnt_n;
  logic [OW-1:0]       winner;
  logic [OW-1:0]       owner_next;
  logic [DATA_W-1:0]   owner_data;

  // First requester at or after the pointer, wrapping past N-1 back to 0.
  function automatic logic [OW-1:0] pick(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(p) + i;
      if (idx >= N) idx = idx - N;
      if (!found && r[idx[OW-1:0]]) begin
        w     = OW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Winner of the scan and the pointer value used after the current owner releases.
  always_comb begin
    winner     = pick(req, ptr);
    owner_next = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  end

  // Select the owner's write-data slice.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == OW'(i)) owner_data = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and registered-output logic; q and owner hold unless explicitly updated.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    owner_n    = owner;
    q_n        = q;
    q_valid_n  = 1'b0;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (|req) begin
          grant_n    = {{(N-1){1'b0}}, 1'b1} << winner;
          owner_n    = winner;
          hold_cnt_n = '0;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (req[owner]) begin
          q_n        = owner_data;
          q_valid_n  = 1'b1;
          hold_cnt_n = hold_cnt + 1'b1;
          if (hold_cnt == LAST_LOAD) begin
            grant_n = '0;
            ptr_n   = owner_next;
            state_n = IDLE;
          end
        end else begin
          // Owner let go: release without loading; pointer moves past it so nobody is skipped.
          grant_n = '0;
          ptr_n   = owner_next;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner    <= owner_n;
      q        <= q_n;
      q_valid  <= q_valid_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with N=4, DATA_W=8, MAX_HOLD=4.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Expected values are hand-derived from the arbitration and load rules.
module tb_rr_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int checks = 0;
  int errors = 0;

  rr_reg_arbiter #(.N(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .grant   (grant),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot;
    int         who;
    reset = 1'b1;
    req   = 4'($urandom);
    wdata = $urandom;

    // Reset with random inputs
    tick();
    req   = 4'($urandom);
    wdata = $urandom;
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    reset = 1'b0;
    req   = 4'b0010;
    wdata = 32'h0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_owner", 32'(owner), 32'h1);
    req = 4'b0000;
    tick();  // owner dropped: release without load, ptr -> 2
    chk("drop_grant", 32'(grant), 32'h0);
    chk("drop_qv", 32'(q_valid), 32'h0);

    // Single short transfer from requester 1 (ptr=2 wraps to 1)
    req = 4'b0010;
    wdata[15:8] = 8'hA5;
    tick();
    chk("short_grant", 32'(grant), 32'h2);
    chk("short_qv0", 32'(q_valid), 32'h0);
    tick();
    chk("short_q1", 32'(q), 32'hA5);
    chk("short_qv1", 32'(q_valid), 32'h1);
    chk("short_grant1", 32'(grant), 32'h2);
    tick();
    chk("short_qv2", 32'(q_valid), 32'h1);
    req = 4'b0000;
    tick();
    chk("short_rel_grant", 32'(grant), 32'h0);
    chk("short_rel_qv", 32'(q_valid), 32'h0);
    chk("short_rel_q", 32'(q), 32'hA5);
    // ptr should now be 2: with req 1011 the scan 2,3 lands on 3
    req = 4'b1011;
    tick();
    chk("ptr2_grant", 32'(grant), 32'h8);
    chk("ptr2_owner", 32'(owner), 32'h3);
    req = 4'b0000;
    tick();  // release, ptr -> 0
    chk("ptr2_rel", 32'(grant), 32'h0);

    // Hold limit on requester 2
    req = 4'b0100;
    wdata[23:16] = 8'h10;
    tick();
    chk("hold_grant", 32'(grant), 32'h4);
    for (int k = 0; k < 4; k++) begin
      wdata[23:16] = 8'(8'h10 + k);
      tick();
      chk($sformatf("hold_q%0d", k), 32'(q), 32'(8'h10 + k));
      chk($sformatf("hold_qv%0d", k), 32'(q_valid), 32'h1);
      chk($sformatf("hold_grant%0d", k), 32'(grant), (k < 3) ? 32'h4 : 32'h0);
    end
    tick();  // turnaround IDLE edge re-grants the still-waiting requester
    chk("hold_regrant", 32'(grant), 32'h4);
    chk("hold_idle_qv", 32'(q_valid), 32'h0);
    chk("hold_q_kept", 32'(q), 32'h13);
    req = 4'b0000;
    tick();  // release, ptr -> 3
    chk("hold_rel", 32'(grant), 32'h0);

    // Wrap and skip: ptr=3, req=0101 -> requester 0
    req   = 4'b0101;
    wdata = 32'h0000_0077;
    tick();
    chk("wrap_grant", 32'(grant), 32'h1);
    chk("wrap_owner", 32'(owner), 32'h0);
    tick();
    chk("wrap_q", 32'(q), 32'h77);
    req = 4'b0100;
    tick();  // release, ptr -> 1
    chk("wrap_rel", 32'(grant), 32'h0);
    tick();
    chk("skip_grant", 32'(grant), 32'h4);
    chk("skip_owner", 32'(owner), 32'h2);
    req = 4'b0000;
    tick();

    // Reset during BUSY
    req   = 4'b0001;
    wdata = 32'h0000_003C;
    tick();
    chk("mid_grant", 32'(grant), 32'h1);
    tick();
    chk("mid_q", 32'(q), 32'h3C);
    reset = 1'b1;
    tick();
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_qv", 32'(q_valid), 32'h0);
    reset = 1'b0;

    // Fairness from ptr=0: each requester takes one load then drops
    wdata = 32'h4433_2211;
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      who    = g % 4;
      onehot = 4'b0001 << who;
      tick();
      chk($sformatf("fair_grant%0d", g), 32'(grant), 32'(onehot));
      tick();
      chk($sformatf("fair_q%0d", g), 32'(q), 32'(8'h11 * (who + 1)));
      chk($sformatf("fair_qv%0d", g), 32'(q_valid), 32'h1);
      req = 4'b1111 & ~onehot;
      tick();
      chk($sformatf("fair_idle%0d", g), 32'(grant), 32'h0);
      req = 4'b1111;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
